// File: rtl/vga_layer_mixer.sv
// Pixel compositor: NUM_BG frame-aligned background channels, NUM_SPR priority sprites, 2-stage colour/sync pipeline.
// Optional MIXER_BLANK_ON_SWITCH_EN: one black frame after every background change.
module vga_layer_mixer #(
    parameter int NUM_BG      = 4,
    parameter int NUM_SPR     = 2,
    parameter int CW          = 2,
    parameter int SELW        = 2,
    parameter int HOLD_FRAMES = 60
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      video_active,
    input  logic                      hsync_in,
    input  logic                      vsync_in,
    input  logic                      frame_tick,
    input  logic [NUM_BG*3*CW-1:0]    bg_rgb,
    input  logic [NUM_SPR*3*CW-1:0]   spr_rgb,
    input  logic [NUM_SPR-1:0]        spr_hit,
    input  logic [SELW-1:0]           bg_sel,
    input  logic                      auto_en,
    output logic [CW-1:0]             R,
    output logic [CW-1:0]             G,
    output logic [CW-1:0]             B,
    output logic                      hsync_out,
    output logic                      vsync_out,
    output logic [SELW-1:0]           cur_bg,
    output logic                      switch_pulse
);
    localparam int PW   = 3 * CW;
    localparam int CNTW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

    logic [SELW-1:0] cur_bg_q, cur_bg_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            switch_q, switch_d;
    logic            bg_changed;
    logic            blank_now;
    logic [PW-1:0]   pix_d, s1_rgb_q, out_rgb_q;
    logic            s1_hs_q, s1_vs_q, out_hs_q, out_vs_q;

    // Scene selection; the counter only runs while auto mode is on, so re-entry restarts the interval.
    always_comb begin
        cur_bg_d = cur_bg_q;
        cnt_d    = cnt_q;
        if (!auto_en) begin
            cnt_d = '0;
        end
        if (frame_tick) begin
            if (auto_en) begin
                if (cnt_q == CNTW'(HOLD_FRAMES - 1)) begin
                    cnt_d    = '0;
                    cur_bg_d = (cur_bg_q == SELW'(NUM_BG - 1)) ? '0 : cur_bg_q + SELW'(1);
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end else if (int'(bg_sel) < NUM_BG) begin
                cur_bg_d = bg_sel;
            end
        end
        bg_changed = (cur_bg_d != cur_bg_q);
        switch_d   = bg_changed;
    end

`ifdef MIXER_BLANK_ON_SWITCH_EN
    logic blank_q, blank_d;
    // Blank from the pixel after a change up to and including the next tick cycle.
    assign blank_d   = frame_tick ? bg_changed : blank_q;
    assign blank_now = blank_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            blank_q <= 1'b0;
        end else begin
            blank_q <= blank_d;
        end
    end
`else
    assign blank_now = 1'b0;
`endif

    // Lowest-index opaque sprite wins, so scan downwards and let the last hit stick.
    always_comb begin
        pix_d = '0;
        for (int i = 0; i < NUM_BG; i++) begin
            if (cur_bg_q == SELW'(i)) begin
                pix_d = bg_rgb[i*PW +: PW];
            end
        end
        for (int j = NUM_SPR - 1; j >= 0; j--) begin
            if (spr_hit[j]) begin
                pix_d = spr_rgb[j*PW +: PW];
            end
        end
        if (!video_active || blank_now) begin
            pix_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_bg_q  <= '0;
            cnt_q     <= '0;
            switch_q  <= 1'b0;
            s1_rgb_q  <= '0;
            s1_hs_q   <= 1'b0;
            s1_vs_q   <= 1'b0;
            out_rgb_q <= '0;
            out_hs_q  <= 1'b0;
            out_vs_q  <= 1'b0;
        end else begin
            cur_bg_q  <= cur_bg_d;
            cnt_q     <= cnt_d;
            switch_q  <= switch_d;
            s1_rgb_q  <= pix_d;
            s1_hs_q   <= hsync_in;
            s1_vs_q   <= vsync_in;
            out_rgb_q <= s1_rgb_q;
            out_hs_q  <= s1_hs_q;
            out_vs_q  <= s1_vs_q;
        end
    end

    assign R            = out_rgb_q[3*CW-1 -: CW];
    assign G            = out_rgb_q[2*CW-1 -: CW];
    assign B            = out_rgb_q[CW-1:0];
    assign hsync_out    = out_hs_q;
    assign vsync_out    = out_vs_q;
    assign cur_bg       = cur_bg_q;
    assign switch_pulse = switch_q;
endmodule

// File: tb/tb_vga_layer_mixer.sv
// Directed bench for vga_layer_mixer (NUM_BG=4, SELW=3, HOLD_FRAMES=3); expectations queued per due cycle.
module tb_vga_layer_mixer;
    localparam int NUM_BG = 4;
    localparam int NUM_SPR = 2;
    localparam int CW = 2;
    localparam int SELW = 3;
    localparam int HOLD = 3;
`ifdef MIXER_BLANK_ON_SWITCH_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    localparam logic [5:0] CH0 = 6'h05, CH1 = 6'h0A, CH2 = 6'h12, CH3 = 6'h2D;
    localparam logic [5:0] SP0 = 6'h15, SP1 = 6'h3F;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic                    video_active = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0, frame_tick = 1'b0;
    logic [NUM_BG*3*CW-1:0]  bg_rgb = {CH3, CH2, CH1, CH0};
    logic [NUM_SPR*3*CW-1:0] spr_rgb = {SP1, SP0};
    logic [NUM_SPR-1:0]      spr_hit = '0;
    logic [SELW-1:0]         bg_sel = '0;
    logic                    auto_en = 1'b0;
    logic [CW-1:0]           R, G, B;
    logic                    hsync_out, vsync_out, switch_pulse;
    logic [SELW-1:0]         cur_bg;

    vga_layer_mixer #(
        .NUM_BG(NUM_BG), .NUM_SPR(NUM_SPR), .CW(CW), .SELW(SELW), .HOLD_FRAMES(HOLD)
    ) dut (
        .clk(clk), .reset(reset), .video_active(video_active), .hsync_in(hsync_in),
        .vsync_in(vsync_in), .frame_tick(frame_tick), .bg_rgb(bg_rgb), .spr_rgb(spr_rgb),
        .spr_hit(spr_hit), .bg_sel(bg_sel), .auto_en(auto_en), .R(R), .G(G), .B(B),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .cur_bg(cur_bg), .switch_pulse(switch_pulse)
    );

    // ---------------- scoreboard ----------------
    // px entry: {due[15:0], rgb[5:0], hs, vs}; ctl entry: {due[15:0], sel[2:0], pulse}
    logic [23:0] px_q[$];
    logic [19:0] ctl_q[$];
    int tests_run = 0;
    int tests_failed = 0;

    always @(negedge clk) begin
        logic [23:0] pe;
        logic [19:0] ce;
        logic [7:0]  pact;
        logic [3:0]  cact;
        while (px_q.size() > 0 && int'(px_q[0][23:8]) <= cyc) begin
            pe = px_q.pop_front();
            pact = {R, G, B, hsync_out, vsync_out};
            tests_run++;
            if (int'(pe[23:8]) != cyc || pact != pe[7:0]) begin
                tests_failed++;
                $display("FAIL pixel cyc=%0d due=%0d actual rgb/hs/vs=%h required=%h",
                         cyc, pe[23:8], pact, pe[7:0]);
            end
        end
        while (ctl_q.size() > 0 && int'(ctl_q[0][19:4]) <= cyc) begin
            ce = ctl_q.pop_front();
            cact = {cur_bg, switch_pulse};
            tests_run++;
            if (int'(ce[19:4]) != cyc || cact != ce[3:0]) begin
                tests_failed++;
                $display("FAIL ctl cyc=%0d due=%0d actual cur_bg=%0d pulse=%0d required cur_bg=%0d pulse=%0d",
                         cyc, ce[19:4], cact[3:1], cact[0], ce[3:1], ce[0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic px(input logic va, input logic [1:0] hit, input logic tick,
                      input logic [5:0] exp_rgb, input bit chk);
        reset        = 1'b0;
        video_active = va;
        spr_hit      = hit;
        frame_tick   = tick;
        hsync_in     = 1'($urandom_range(0, 1));
        vsync_in     = 1'($urandom_range(0, 1));
        if (chk) px_q.push_back({16'(cyc + 2), exp_rgb, hsync_in, vsync_in});
        @(posedge clk); #1;
        frame_tick = 1'b0;
    endtask

    // Tick cycle: the pixel sampled here still uses the old scene.
    task automatic tick_px(input logic va, input logic [5:0] exp_rgb,
                           input logic [2:0] exp_sel, input logic exp_pulse);
        ctl_q.push_back({16'(cyc + 1), exp_sel, exp_pulse});
        ctl_q.push_back({16'(cyc + 2), exp_sel, 1'b0});
        px(va, 2'b00, 1'b1, exp_rgb, 1'b1);
    endtask

    // Reset held with a simultaneous tick to show reset wins.
    task automatic rst_cycle();
        reset        = 1'b1;
        frame_tick   = 1'b1;
        bg_sel       = 3'd3;
        video_active = 1'b1;
        px_q.push_back({16'(cyc + 1), 8'h00});
        ctl_q.push_back({16'(cyc + 1), 3'd0, 1'b0});
        @(posedge clk); #1;
        frame_tick = 1'b0;
        bg_sel     = 3'd0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [2:0] s;
        @(posedge clk); #1;
        repeat (3) rst_cycle();

        // Reset release: background channel 0, syncs delayed by 2
        repeat (4) px(1'b1, 2'b00, 1'b0, CH0, 1'b1);

        // Manual switch to channel 2
        bg_sel = 3'd2;
        tick_px(1'b1, CH0, 3'd2, 1'b1);
        repeat (3) px(1'b1, 2'b00, 1'b0, BLANK ? 6'h00 : CH2, 1'b1);
        tick_px(1'b1, BLANK ? 6'h00 : CH2, 3'd2, 1'b0);
        repeat (2) px(1'b1, 2'b00, 1'b0, CH2, 1'b1);

        // Out-of-range selects are ignored
        bg_sel = 3'd5;
        tick_px(1'b1, CH2, 3'd2, 1'b0);
        px(1'b1, 2'b00, 1'b0, CH2, 1'b1);
        bg_sel = 3'd4;
        tick_px(1'b1, CH2, 3'd2, 1'b0);
        px(1'b1, 2'b00, 1'b0, CH2, 1'b1);
        bg_sel = 3'd2;

        // Sprite priority and blanking
        px(1'b1, 2'b11, 1'b0, SP0, 1'b1);
        px(1'b1, 2'b10, 1'b0, SP1, 1'b1);
        px(1'b1, 2'b01, 1'b0, SP0, 1'b1);
        px(1'b0, 2'b11, 1'b0, 6'h00, 1'b1);
        px(1'b0, 2'b00, 1'b0, 6'h00, 1'b1);
        px(1'b1, 2'b00, 1'b0, CH2, 1'b1);

        // Mid-run reset, then auto mode (pixels blanked by video_active=0)
        px(1'b1, 2'b00, 1'b0, 6'h00, 1'b0);
        repeat (2) rst_cycle();
        bg_sel  = 3'd0;
        auto_en = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            s = 3'((k / HOLD) % NUM_BG);
            tick_px(1'b0, 6'h00, s, (k % HOLD) == 0);
            px(1'b0, 2'b00, 1'b0, 6'h00, 1'b1);
        end

        // One auto tick, then a manual tick clears the count; re-entry needs a full interval
        tick_px(1'b0, 6'h00, 3'd0, 1'b0);
        px(1'b0, 2'b00, 1'b0, 6'h00, 1'b1);
        auto_en = 1'b0;
        bg_sel  = 3'd0;
        tick_px(1'b0, 6'h00, 3'd0, 1'b0);
        px(1'b0, 2'b00, 1'b0, 6'h00, 1'b1);
        auto_en = 1'b1;
        tick_px(1'b0, 6'h00, 3'd0, 1'b0);
        px(1'b0, 2'b00, 1'b0, 6'h00, 1'b1);
        tick_px(1'b0, 6'h00, 3'd0, 1'b0);
        px(1'b0, 2'b00, 1'b0, 6'h00, 1'b1);
        tick_px(1'b0, 6'h00, 3'd1, 1'b1);
        px(1'b0, 2'b00, 1'b0, 6'h00, 1'b1);

        // Drain and make sure every expectation was consumed
        repeat (4) px(1'b0, 2'b00, 1'b0, 6'h00, 1'b0);
        @(posedge clk); #1;
        tests_run++;
        if (px_q.size() != 0 || ctl_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain actual pending px=%0d ctl=%0d required 0/0", px_q.size(), ctl_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/vga_layer_mixer.md
# vga_layer_mixer

Parametrised pixel compositor between the VGA timing/pattern generators and the TinyVGA output register. It generalises the fixed 4-way background select into NUM_BG background channels plus NUM_SPR priority sprite layers. Background changes are frame-aligned, and an auto-cycle mode steps through scenes. Syncs are delayed to stay aligned with the 2-cycle colour pipeline.

## Interface
Parameters:
- NUM_BG, 4: number of background channels (2..16)
- NUM_SPR, 2: number of sprite layers (1..8)
- CW, 2: bits per colour component
- SELW, 2: width of background index; must satisfy 2^SELW >= NUM_BG
- HOLD_FRAMES, 60: frames per scene in auto mode (>=1)

Ports:
- clk  input  1  pixel clock
- reset  input  1  synchronous, active-high reset
- video_active  input  1  display-on from hvsync_generator
- hsync_in  input  1  raw hsync
- vsync_in  input  1  raw vsync
- frame_tick  input  1  one-cycle pulse at start of each frame
- bg_rgb  input  NUM_BG*3*CW  channel i at [i*3*CW +: 3*CW], packed {R,G,B}, R in MSBs
- spr_rgb  input  NUM_SPR*3*CW  sprite j colour, same packing
- spr_hit  input  NUM_SPR  bit j high = sprite j opaque at this pixel
- bg_sel  input  SELW  manual background index
- auto_en  input  1  1 = auto-cycle, 0 = manual
- R, G, B  output  CW each  composited colour
- hsync_out, vsync_out  output  1 each  syncs delayed 2 cycles
- cur_bg  output  SELW  active background index
- switch_pulse  output  1  one-cycle pulse when cur_bg changes

## Operation
- Reset: R/G/B = 0, hsync_out = vsync_out = 0, cur_bg = 0, switch_pulse = 0, hold counter = 0, pipeline registers = 0.
- Scene selection is updated only in cycles with frame_tick = 1:
  - Manual mode: if bg_sel < NUM_BG and bg_sel != cur_bg, then cur_bg <= bg_sel. An out-of-range bg_sel is ignored and cur_bg is held.
  - Auto mode: the hold counter increments on each tick. At count HOLD_FRAMES-1 the counter clears and cur_bg advances, wrapping from NUM_BG-1 to 0.
  - The hold counter clears whenever auto_en = 0. Re-entering auto mode starts a full HOLD_FRAMES interval.
  - switch_pulse = 1 in the cycle after any tick that changed cur_bg.
- Composition per pixel, in priority order:
  1. video_active = 0: output black.
  2. Otherwise the lowest-index j with spr_hit[j] = 1 supplies the colour.
  3. Otherwise the colour comes from background channel cur_bg.
- Arithmetic: the hold counter is clog2(HOLD_FRAMES) bits, minimum 1 bit. There is no colour arithmetic; colours are selected, never blended.

## Timing
- Stage 1: inputs sampled in cycle n. Select and blank decision registered.
- Stage 2: R/G/B, hsync_out and vsync_out valid at cycle n+2. Syncs pass through the same 2-stage shift, so colour and sync stay aligned.
- A tick in cycle n updates cur_bg at the edge ending cycle n.
  - Pixels sampled in cycle n use the old background.
  - Pixels sampled in cycle n+1 and later use the new background.
- Background change appears at the outputs from cycle n+3.
- Reset asserted in any cycle clears all state at that edge. Reset wins over a simultaneous frame_tick. Output returns to valid colour 2 cycles after reset deasserts.
- Mode change and tick in the same cycle: the tick is evaluated under the new auto_en value.

## Configuration
- MIXER_BLANK_ON_SWITCH_EN defined:
  - After any cur_bg change, R/G/B are forced to 0 for every pixel until the next frame_tick, giving one black frame between scenes.
  - Sprites are also blanked during this frame.
  - Syncs are unaffected.
- Undefined: scene changes cut directly, with no blank frame.

## Test plan
- Reset, then video_active = 1 with distinct colours on all channels -> R/G/B equal bg channel 0 two cycles after reset release; syncs are the inputs delayed by exactly 2 cycles.
- Manual mode, bg_sel = 2, tick in cycle 10 -> cur_bg = 2 from cycle 11, switch_pulse high in cycle 11 only, channel-2 colour at outputs from cycle 13. Repeating the tick with bg_sel = 2 -> no pulse.
- bg_sel = 5 with NUM_BG = 4, tick -> cur_bg unchanged, no switch_pulse.
- spr_hit = 2'b11, spr_rgb = {6'h3F, 6'h15} -> output 6'h15 (sprite 0). spr_hit = 2'b10 -> 6'h3F. video_active = 0 -> 0 regardless.
- Auto mode, HOLD_FRAMES = 3, NUM_BG = 4, 12 ticks -> cur_bg sequence 1,2,3,0 on ticks 3,6,9,12. Dropping auto_en for 1 tick then restoring -> next advance 3 ticks later.
- With MIXER_BLANK_ON_SWITCH_EN defined: after a switch, all pixels 0 until the next tick, then new colours. Without the macro, new colours appear immediately.
